// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pre-add, signed multiply, post-add/accumulate pipeline with saturation, overflow and pattern detect
module dsp_mac_pipe #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int C_WIDTH = 48,
  parameter int P_WIDTH = 48,
  parameter bit MREG = 1'b1,
  parameter bit SATURATE = 1'b0,
  parameter logic [P_WIDTH-1:0] PATTERN = '0,
  parameter logic [P_WIDTH-1:0] MASK = '0
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       CE,
  input  logic                       valid_in,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  input  logic [B_WIDTH-1:0]         D,
  input  logic [C_WIDTH-1:0]         C,
  input  logic [P_WIDTH-1:0]         PCIN,
  input  logic                       CARRYIN,
  input  logic [7:0]                 OPMODE,
  output logic [P_WIDTH-1:0]         P,
  output logic [P_WIDTH-1:0]         PCOUT,
  output logic [B_WIDTH-1:0]         BCOUT,
  output logic [A_WIDTH+B_WIDTH-1:0] M,
  output logic                       CARRYOUT,
  output logic                       OVERFLOW,
  output logic                       PATTERN_DETECT,
  output logic                       valid_out
);
  localparam int MW = A_WIDTH + B_WIDTH;
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q, d_q, bc_q, pre;
  logic [C_WIDTH-1:0] c_q, c_f;
  logic [P_WIDTH-1:0] pcin_q, pcin_f, p_q, p_d, x, z;
  logic [7:0] op_q, op_f;
  logic [MW-1:0] prod;
  logic [P_WIDTH:0] r;
  logic [P_WIDTH+1:0] s;
  logic cin_q, cin_f, v1_q, v_f, ci, co_q, co_d, ov_q, ov_d, vo_q;
  logic unused_bits;
  always_ff @(posedge clk)
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      c_q <= '0;
      pcin_q <= '0;
      cin_q <= 1'b0;
      op_q <= '0;
      v1_q <= 1'b0;
      bc_q <= '0;
    end else if (CE) begin
      a_q <= A;
      b_q <= B;
      d_q <= D;
      c_q <= C;
      pcin_q <= PCIN;
      cin_q <= CARRYIN;
      op_q <= OPMODE;
      v1_q <= valid_in;
      bc_q <= pre;
    end
  always_comb begin
    pre = op_q[0] ? (op_q[1] ? d_q - b_q : d_q + b_q) : b_q;
    prod = MW'($signed(a_q)) * MW'($signed(pre));
  end
  if (MREG) begin : g_mreg
    logic [MW-1:0] m_q;
    logic [C_WIDTH-1:0] c2_q;
    logic [P_WIDTH-1:0] pcin2_q;
    logic [7:0] op2_q;
    logic cin2_q, v2_q;
    always_ff @(posedge clk)
      if (RST) begin
        m_q <= '0;
        c2_q <= '0;
        pcin2_q <= '0;
        op2_q <= '0;
        cin2_q <= 1'b0;
        v2_q <= 1'b0;
      end else if (CE) begin
        m_q <= prod;
        c2_q <= c_q;
        pcin2_q <= pcin_q;
        op2_q <= op_q;
        cin2_q <= cin_q;
        v2_q <= v1_q;
      end
    assign M = m_q;
    assign c_f = c2_q;
    assign pcin_f = pcin2_q;
    assign op_f = op2_q;
    assign cin_f = cin2_q;
    assign v_f = v2_q;
  end else begin : g_nomreg
    assign M = prod;
    assign c_f = c_q;
    assign pcin_f = pcin_q;
    assign op_f = op_q;
    assign cin_f = cin_q;
    assign v_f = v1_q;
  end
  always_comb begin
    ci = op_f[6] & cin_f;
    x = op_f[4] ? P_WIDTH'($signed(M)) : '0;
    z = op_f[3] ? (op_f[2] ? pcin_f : P_WIDTH'($signed(c_f))) : (op_f[2] ? p_q : '0);
    r = op_f[5] ? {1'b0, z} - {1'b0, x} - (P_WIDTH+1)'(ci) : {1'b0, z} + {1'b0, x} + (P_WIDTH+1)'(ci);
    s = op_f[5] ? {{2{z[P_WIDTH-1]}}, z} - {{2{x[P_WIDTH-1]}}, x} - (P_WIDTH+2)'(ci)
                : {{2{z[P_WIDTH-1]}}, z} + {{2{x[P_WIDTH-1]}}, x} + (P_WIDTH+2)'(ci);
    ov_d = (s[P_WIDTH+1:P_WIDTH-1] != '0) && (s[P_WIDTH+1:P_WIDTH-1] != '1);
    p_d = (ov_d && SATURATE) ? {s[P_WIDTH+1], {(P_WIDTH-1){~s[P_WIDTH+1]}}} : s[P_WIDTH-1:0];
    co_d = r[P_WIDTH];
  end
  always_ff @(posedge clk)
    if (RST) begin
      p_q <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
      vo_q <= 1'b0;
    end else if (CE) begin
      p_q <= p_d;
      co_q <= co_d;
      ov_q <= ov_d;
      vo_q <= v_f;
    end
  assign P = p_q;
  assign PCOUT = p_q;
  assign BCOUT = bc_q;
  assign CARRYOUT = co_q;
  assign OVERFLOW = ov_q;
  assign valid_out = vo_q;
  assign PATTERN_DETECT = ((p_q ^ PATTERN) & ~MASK) == '0;
  assign unused_bits = ^{op_f[7], op_f[1:0], r[P_WIDTH-1:0]};
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed and random checks of two dsp_mac_pipe configurations against an arithmetic model
module tb_dsp_mac_pipe;
  typedef struct packed {
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic cin;
    logic [7:0] op;
    logic v;
  } beat_t;
  localparam longint M48 = (64'sd1 <<< 48) - 1;
  localparam longint M36 = (64'sd1 <<< 36) - 1;
  localparam longint M18 = (64'sd1 <<< 18) - 1;
  localparam longint PMAX = (64'sd1 <<< 47) - 1;
  localparam longint PMIN = -(64'sd1 <<< 47);
  localparam longint PAT0 = 300, MSK0 = 0, PAT1 = 'h100, MSK1 = 'hFF;
  logic clk = 1'b0, RST = 1'b1, CE = 1'b0, valid_in = 1'b0, CARRYIN = 1'b0;
  logic [17:0] A = '0, B = '0, D = '0;
  logic [47:0] C = '0, PCIN = '0;
  logic [7:0] OPMODE = '0;
  logic [47:0] p0, pc0, p1, pc1;
  logic [17:0] bc0, bc1;
  logic [35:0] m0, m1;
  logic co0, ov0, pd0, vo0, co1, ov1, pd1, vo1;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  beat_t h[$];
  longint mp[2];
  bit eco[2], eov[2], ev[2];
  longint pn;
  bit fco, fov;
  always #5 clk = ~clk;
  dsp_mac_pipe #(.MREG(1'b1), .SATURATE(1'b1), .PATTERN(48'd300), .MASK(48'd0)) dut (
    .clk(clk), .RST(RST), .CE(CE), .valid_in(valid_in), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .OPMODE(OPMODE), .P(p0), .PCOUT(pc0), .BCOUT(bc0), .M(m0), .CARRYOUT(co0),
    .OVERFLOW(ov0), .PATTERN_DETECT(pd0), .valid_out(vo0));
  dsp_mac_pipe #(.MREG(1'b0), .SATURATE(1'b0), .PATTERN(48'h100), .MASK(48'hFF)) dut2 (
    .clk(clk), .RST(RST), .CE(CE), .valid_in(valid_in), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .OPMODE(OPMODE), .P(p1), .PCOUT(pc1), .BCOUT(bc1), .M(m1), .CARRYOUT(co1),
    .OVERFLOW(ov1), .PATTERN_DETECT(pd1), .valid_out(vo1));
  function automatic longint sx(input logic [63:0] v, input int w);
    longint r;
    r = longint'(v) & ((64'sd1 <<< w) - 1);
    return (r >= (64'sd1 <<< (w - 1))) ? r - (64'sd1 <<< w) : r;
  endfunction
  function automatic longint pre_v(input beat_t t);
    longint dd, bb;
    dd = sx(64'(t.d), 18);
    bb = sx(64'(t.b), 18);
    return t.op[0] ? sx(t.op[1] ? dd - bb : dd + bb, 18) : bb;
  endfunction
  function automatic longint prod_v(input beat_t t);
    return sx(64'(t.a), 18) * pre_v(t);
  endfunction
  function automatic void fin(input beat_t t, input longint pp, input bit sat,
                              output longint pnew, output bit co, output bit ov);
    longint zz, xx, ci, sum;
    case (t.op[3:2])
      2'd0: zz = 0;
      2'd1: zz = pp;
      2'd2: zz = sx(64'(t.c), 48);
      default: zz = sx(64'(t.pcin), 48);
    endcase
    xx = t.op[4] ? prod_v(t) : 0;
    ci = (t.op[6] && t.cin) ? 1 : 0;
    sum = t.op[5] ? zz - xx - ci : zz + xx + ci;
    ov = (sum > PMAX) || (sum < PMIN);
    pnew = (ov && sat) ? ((sum > PMAX) ? PMAX : PMIN) : sx(64'(sum), 48);
    co = t.op[5] ? ((zz & M48) < (xx & M48) + ci) : ((((zz & M48) + (xx & M48) + ci) >>> 48) != 0);
  endfunction
  always @(posedge clk)
    if (RST) begin
      h.delete();
      repeat (3) h.push_back('0);
      for (int k = 0; k < 2; k++) begin
        mp[k] = 0;
        eco[k] = 1'b0;
        eov[k] = 1'b0;
        ev[k] = 1'b0;
      end
    end else if (CE) begin
      h.push_front({A, B, D, C, PCIN, CARRYIN, OPMODE, valid_in});
      void'(h.pop_back());
      for (int k = 0; k < 2; k++) begin
        fin(h[k == 0 ? 2 : 1], mp[k], k == 0, pn, fco, fov);
        mp[k] = pn;
        eco[k] = fco;
        eov[k] = fov;
        ev[k] = h[k == 0 ? 2 : 1].v;
      end
    end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_dut(input int k, input logic [47:0] p, input logic [47:0] pc, input logic [17:0] bc,
                         input logic [35:0] m, input logic co, input logic ov, input logic pd, input logic vo);
    longint pe, pat, msk;
    pe = mp[k] & M48;
    pat = (k == 0) ? PAT0 : PAT1;
    msk = (k == 0) ? MSK0 : MSK1;
    chk($sformatf("dut%0d_P", k), 64'(p), pe);
    chk($sformatf("dut%0d_PCOUT", k), 64'(pc), pe);
    chk($sformatf("dut%0d_BCOUT", k), 64'(bc), pre_v(h[1]) & M18);
    chk($sformatf("dut%0d_M", k), 64'(m), prod_v(h[k == 0 ? 1 : 0]) & M36);
    chk($sformatf("dut%0d_CARRYOUT", k), 64'(co), 64'(eco[k]));
    chk($sformatf("dut%0d_OVERFLOW", k), 64'(ov), 64'(eov[k]));
    chk($sformatf("dut%0d_PDET", k), 64'(pd), 64'(((pe ^ pat) & ~msk & M48) == 0));
    chk($sformatf("dut%0d_VALID", k), 64'(vo), 64'(ev[k]));
  endtask
  always @(negedge clk)
    if (chk_en) begin
      cmp_dut(0, p0, pc0, bc0, m0, co0, ov0, pd0, vo0);
      cmp_dut(1, p1, pc1, bc1, m1, co1, ov1, pd1, vo1);
    end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic set_beat(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d, input logic [47:0] c,
                          input logic [47:0] pcin, input logic cin, input logic [7:0] op, input logic v);
    A = a;
    B = b;
    D = d;
    C = c;
    PCIN = pcin;
    CARRYIN = cin;
    OPMODE = op;
    valid_in = v;
  endtask
  initial begin
    RST = 1'b1;
    CE = 1'($urandom);
    set_beat(18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}), 48'({$urandom, $urandom}),
             1'($urandom), 8'($urandom), 1'b1);
    cyc();
    chk("rst_P0", 64'(p0), 64'd0);
    chk("rst_PC0", 64'(pc0), 64'd0);
    chk("rst_M0", 64'(m0), 64'd0);
    chk("rst_BC0", 64'(bc0), 64'd0);
    chk("rst_flags0", 64'({co0, ov0, vo0, pd0}), 64'd0);
    chk("rst_P1", 64'(p1), 64'd0);
    chk("rst_M1", 64'(m1), 64'd0);
    chk("rst_flags1", 64'({co1, ov1, vo1, pd1}), 64'd0);
    chk_en = 1'b1;
    RST = 1'b0;
    CE = 1'b1;
    set_beat(18'd20, 18'd10, 18'd25, 48'd0, 48'd0, 1'b0, 8'h13, 1'b1);
    cyc();
    valid_in = 1'b0;
    cyc();
    chk("presub_valid_early", 64'(vo0), 64'd0);
    chk("presub_BCOUT", 64'(bc0), 64'd15);
    chk("presub_M", 64'(m0), 64'h12C);
    cyc();
    chk("presub_P", 64'(p0), 64'h12C);
    chk("presub_valid", 64'(vo0), 64'd1);
    chk("presub_PDET", 64'(pd0), 64'd1);
    chk("presub_P_mreg0", 64'(p1), 64'h12C);
    CE = 1'b0;
    set_beat(18'd7, 18'd9, 18'd3, 48'd5, 48'd0, 1'b1, 8'h18, 1'b1);
    cyc();
    cyc();
    chk("cehold_P", 64'(p0), 64'h12C);
    chk("cehold_valid", 64'(vo0), 64'd1);
    chk("cehold_PDET", 64'(pd0), 64'd1);
    CE = 1'b1;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    set_beat(18'd2, 18'd3, 18'd0, 48'd0, 48'd0, 1'b0, 8'h14, 1'b1);
    cyc();
    cyc();
    cyc();
    chk("acc_P6", 64'(p0), 64'd6);
    cyc();
    chk("acc_P12", 64'(p0), 64'd12);
    OPMODE = 8'h04;
    valid_in = 1'b0;
    cyc();
    chk("acc_P18", 64'(p0), 64'd18);
    cyc();
    chk("acc_P24", 64'(p0), 64'd24);
    cyc();
    cyc();
    chk("acc_hold", 64'(p0), 64'd24);
    chk("acc_hold_mreg0", 64'(p1), 64'd24);
    set_beat(18'd5, 18'd6, 18'd0, 48'd350, 48'd0, 1'b1, 8'h78, 1'b1);
    repeat (3) cyc();
    chk("postsub_P", 64'(p0), 64'd319);
    chk("postsub_M", 64'(m0), 64'd30);
    chk("postsub_CO", 64'(co0), 64'd0);
    chk("postsub_P_mreg0", 64'(p1), 64'd319);
    chk("postsub_PDET_masked", 64'(pd1), 64'd1);
    set_beat(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 48'd0, 1'b0, 8'h18, 1'b1);
    repeat (3) cyc();
    chk("ovf_sat_P", 64'(p0), 64'h7FFF_FFFF_FFFF);
    chk("ovf_sat_OV", 64'(ov0), 64'd1);
    chk("ovf_wrap_P", 64'(p1), 64'h8000_0000_0000);
    chk("ovf_wrap_OV", 64'(ov1), 64'd1);
    for (int i = 0; i < 300; i++) begin
      RST = ($urandom_range(0, 24) == 0);
      CE = ($urandom_range(0, 3) != 0);
      set_beat(18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
               48'({$urandom, $urandom}), 1'($urandom), 8'($urandom), 1'($urandom));
      cyc();
    end
    RST = 1'b0;
    CE = 1'b1;
    set_beat(18'h3FFFF, 18'h20000, 18'h1FFFF, 48'h8000_0000_0000, 48'h0, 1'b1, 8'h7B, 1'b1);
    repeat (4) cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
